// File: rtl/rpn_stack.sv
// rpn_stack: parametrised RPN operand stack (entry 0 = top) feeding the ALU.
// Ports: Clk/Rst (async active-low), CmdValid+Cmd+Din command input, ErrClr clears the sticky Err;
// T0..T2 top entries, Count occupancy, Full/Empty decodes, Err sticky illegal-command flag.
module rpn_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CmdValid,
  input  logic [2:0]       Cmd,
  input  logic [WIDTH-1:0] Din,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] T0,
  output logic [WIDTH-1:0] T1,
  output logic [WIDTH-1:0] T2,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Empty,
  output logic             Err
);
  localparam logic [2:0] C_PUSH = 3'd1;
  localparam logic [2:0] C_POP  = 3'd2;
  localparam logic [2:0] C_DUP  = 3'd3;
  localparam logic [2:0] C_SWAP = 3'd4;
  localparam logic [2:0] C_REP2 = 3'd5;
  localparam logic [2:0] C_CLR  = 3'd6;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [WIDTH-1:0] dn [DEPTH];
  logic [WIDTH-1:0] up [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic full, empty, lt2;
  assign full  = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
  assign lt2   = cnt_q < CW'(2);
  // Vacated slots are refilled with zero so entries at index >= Count always read 0.
  always_comb begin
    dn[0] = Din;
    for (int i = 1; i < DEPTH; i++) dn[i] = stk_q[i-1];
    up[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH - 1; i++) up[i] = stk_q[i+1];
  end
  // Illegal commands leave the stack untouched and only set Err; the set overrides ErrClr.
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    err_d = err_q & ~ErrClr;
    if (CmdValid) begin
      case (Cmd)
        C_PUSH: if (full) err_d = 1'b1;
                else begin stk_d = dn; cnt_d = cnt_q + 1'b1; end
        C_POP:  if (empty) err_d = 1'b1;
                else begin stk_d = up; cnt_d = cnt_q - 1'b1; end
        C_DUP:  if (full || empty) err_d = 1'b1;
                else begin stk_d = dn; stk_d[0] = stk_q[0]; cnt_d = cnt_q + 1'b1; end
        C_SWAP: if (lt2) err_d = 1'b1;
                else begin stk_d[0] = stk_q[1]; stk_d[1] = stk_q[0]; end
        C_REP2: if (lt2) err_d = 1'b1;
                else begin stk_d = up; stk_d[0] = Din; cnt_d = cnt_q - 1'b1; end
        C_CLR:  begin
                  for (int i = 0; i < DEPTH; i++) stk_d[i] = '0;
                  cnt_d = '0;
                  err_d = 1'b0;
                end
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stk_q <= '{default: '0};
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign T0    = stk_q[0];
  assign T1    = stk_q[1];
  assign T2    = stk_q[2];
  assign Count = cnt_q;
  assign Full  = full;
  assign Empty = empty;
  assign Err   = err_q;
endmodule
